// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package hazard_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int MAX_DEPTH  = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_EMPTY = '{valid: 1'b0, dst: {REG_ADDR_W{1'b0}}, is_load: 1'b0};

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: shift register of in-flight destinations checked against decode sources.
// Optional macro HAZARD_FWD_EN: only load-use on the immediately preceding instruction stalls.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr,
    input  logic                          id_dst_write,
    input  logic                          id_dst_is_load,
    input  logic                          flush,
    input  logic                          cnt_clr,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cycles
);

    sb_entry_t                  entry_q [DEPTH];
    sb_entry_t                  entry_d [DEPTH];
    logic [NUM_SRC*DEPTH-1:0]   match_s;
    logic                       stall_s;
    logic                       unused_bits_s;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_ent
`ifdef HAZARD_FWD_EN
            // with bypassing only a load still in ID/EX cannot be forwarded in time
            if (gj == 0) begin : g_load_use
                assign match_s[gi*DEPTH+gj] = id_valid & id_src_used[gi] & entry_q[gj].valid &
                                              entry_q[gj].is_load &
                                              (id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W] == entry_q[gj].dst);
            end else begin : g_fwd
                assign match_s[gi*DEPTH+gj] = 1'b0;
            end
`else
            assign match_s[gi*DEPTH+gj] = id_valid & id_src_used[gi] & entry_q[gj].valid &
                                          (id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W] == entry_q[gj].dst);
`endif
        end
    end

    assign stall_s = ~flush & (|match_s);
    assign stall   = stall_s;

    // scoreboard next state: flush squashes everything, otherwise shift and insert decode
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entry_d[k] = entry_q[k];
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_d[k] = SB_ENTRY_EMPTY;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                entry_d[k] = entry_q[k-1];
            end
            entry_d[0].valid = id_valid & id_dst_write & ~stall_s;
            entry_d[0].dst   = id_dst_addr;
`ifdef HAZARD_FWD_EN
            entry_d[0].is_load = id_dst_is_load;
`else
            entry_d[0].is_load = 1'b0;
`endif
        end
    end

    // scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= SB_ENTRY_EMPTY;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= entry_d[k];
            end
        end
    end

    // fields not consulted in every configuration are folded here
    always_comb begin
        unused_bits_s = id_dst_is_load;
        for (int k = 0; k < DEPTH; k++) begin
            unused_bits_s = unused_bits_s ^ (^entry_q[k]);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall_s),
        .clr_i   (cnt_clr),
        .count_o (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (DEPTH=2, NUM_SRC=2, CNT_W=4).
module tb_hazard_scoreboard;

    localparam int AW    = 3;
    localparam int NS    = 2;
    localparam int DEPTH = 2;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [NS*AW-1:0] id_src_addr;
    logic [NS-1:0] id_src_used;
    logic [AW-1:0] id_dst_addr;
    logic          id_dst_write;
    logic          id_dst_is_load;
    logic          flush;
    logic          cnt_clr;
    logic          stall;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    // model: cycles each register remains unavailable, plus the counter
    int busy [8];
    int mcnt;

    hazard_scoreboard #(
        .REG_ADDR_W (AW),
        .NUM_SRC    (NS),
        .DEPTH      (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_src_addr    (id_src_addr),
        .id_src_used    (id_src_used),
        .id_dst_addr    (id_dst_addr),
        .id_dst_write   (id_dst_write),
        .id_dst_is_load (id_dst_is_load),
        .flush          (flush),
        .cnt_clr        (cnt_clr),
        .stall          (stall),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] s0;
        logic [2:0] s1;
        logic [1:0] used;
        logic [2:0] dst;
        logic       wr;
        logic       ld;
        logic       fl;
        logic       clr;
        logic       exp_stall;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [18];

    function automatic void model_reset();
        for (int r = 0; r < 8; r++) busy[r] = 0;
        mcnt = 0;
    endfunction

    function automatic logic model_stall();
        logic s;
        s = 1'b0;
        if (id_valid && !flush) begin
            if (id_src_used[0] && busy[id_src_addr[2:0]] > 0) s = 1'b1;
            if (id_src_used[1] && busy[id_src_addr[5:3]] > 0) s = 1'b1;
        end
        return s;
    endfunction

    function automatic void model_edge();
        logic s;
        s = model_stall();
        if (cnt_clr) mcnt = 0;
        else if (s && mcnt < (1 << CW) - 1) mcnt = mcnt + 1;
        if (flush) begin
            for (int r = 0; r < 8; r++) busy[r] = 0;
        end else begin
            for (int r = 0; r < 8; r++) if (busy[r] > 0) busy[r] = busy[r] - 1;
            if (id_valid && id_dst_write && !s) begin
`ifdef HAZARD_FWD_EN
                busy[id_dst_addr] = id_dst_is_load ? 1 : 0;
`else
                busy[id_dst_addr] = DEPTH;
`endif
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] u,
                         input logic [2:0] d, input logic w, input logic l, input logic f, input logic c);
        id_valid       = v;
        id_src_addr    = {s1, s0};
        id_src_used    = u;
        id_dst_addr    = d;
        id_dst_write   = w;
        id_dst_is_load = l;
        flush          = f;
        cnt_clr        = c;
    endtask

    // compare against the model mid-cycle, then advance one clock
    task automatic step(input string tag);
        @(negedge clk);
        chk({tag, "_stall"}, int'(stall), int'(model_stall()));
        chk({tag, "_cnt"}, int'(stall_cycles), mcnt);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 3'd3, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[2]  = '{1'b1, 3'd3, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[3]  = '{1'b1, 3'd3, 3'd0, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[4]  = '{1'b1, 3'd0, 3'd5, 2'b01, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b1, 3'd0, 3'd5, 2'b01, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b1, 3'd2, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[7]  = '{1'b1, 3'd2, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b1, 3'd0, 3'd0, 2'b00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{1'b1, 3'd6, 3'd6, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vecs[10] = '{1'b0, 3'd6, 3'd6, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[11] = '{1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        vecs[12] = '{1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        vecs[13] = '{1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[14] = '{1'b1, 3'd1, 3'd1, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[15] = '{1'b1, 3'd0, 3'd1, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[16] = '{1'b1, 3'd0, 3'd1, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[17] = '{1'b1, 3'd0, 3'd1, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        do_reset();
        @(negedge clk);
        chk("reset_stall", int'(stall), 0);
        chk("reset_cnt", int'(stall_cycles), 0);

        // directed table
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].valid, vecs[i].s0, vecs[i].s1, vecs[i].used, vecs[i].dst,
                  vecs[i].wr, vecs[i].ld, vecs[i].fl, vecs[i].clr);
            @(negedge clk);
`ifndef HAZARD_FWD_EN
            chk($sformatf("vec%0d_stall", i), int'(stall), int'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_cnt", i), int'(stall_cycles), vecs[i].exp_cnt);
`endif
            chk($sformatf("vec%0d_model", i), int'(stall), int'(model_stall()));
            @(posedge clk);
            model_edge();
            #1;
        end

        // forwarding: load-use stalls once, ALU-use never
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step("fwd_ld");
        drive(1'b1, 3'd4, 3'd0, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step("fwd_ld_use");
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        step("fwd_alu");
        drive(1'b1, 3'd0, 3'd4, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step("fwd_alu_use");

        // saturation: self-dependent chain keeps stalling
        drive(1'b1, 3'd7, 3'd0, 2'b01, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40) step("sat");
`ifndef HAZARD_FWD_EN
        chk("sat_value", int'(stall_cycles), 15);
`endif
        begin : clr_when_stalled
            int guard;
            guard = 0;
            while (model_stall() == 1'b0 && guard < 10) begin
                step("sat_wait");
                guard++;
            end
        end
        cnt_clr = 1'b1;
        step("clr_stall");
        cnt_clr = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("clr_after");

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  2'($urandom), 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
            step("rnd");
        end

        // async reset while stalled
        drive(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        step("rst_pre");
        drive(1'b1, 3'd2, 3'd2, 2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_pre_stall", int'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_stall", int'(stall), 0);
        chk("rst_async_cnt", int'(stall_cycles), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage RAW hazard detector.
- Tracks the destination registers of in-flight instructions in an internal DEPTH-entry shift scoreboard instead of taking per-stage dst/write ports.
- Compares up to NUM_SRC decode source operands against the scoreboard and asserts stall; handles flush and keeps a saturating stall-cycle counter.
- Sits between fetch/decode and the ID/EX pipeline register; stall freezes PC and IF/ID and injects a bubble.

Parameters:
- REG_ADDR_W, 3, register-specifier width (8 GPRs).
- NUM_SRC, 2, number of source operands compared per decode instruction.
- DEPTH, 2, scoreboard entries; entry 0 = ID/EX, entry DEPTH-1 = oldest tracked stage. Legal range 1..4.
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  decode holds a real instruction.
- id_src_addr  input  NUM_SRC*REG_ADDR_W  source specifiers; src i in bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  input  NUM_SRC  per-source "operand actually read" (replaces single potRAW).
- id_dst_addr  input  REG_ADDR_W  decode destination.
- id_dst_write  input  1  decode instruction writes the register file.
- id_dst_is_load  input  1  decode instruction is a load (used only with FWD_EN).
- flush  input  1  branch/jump redirect; squash decode and all tracked entries.
- cnt_clr  input  1  synchronous clear of stall_cycles.
- stall  output  1  combinational stall request.
- stall_cycles  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Scoreboard: DEPTH entries of {valid, dst, is_load}. All valid bits and stall_cycles are 0 at reset. stall is 0 while rst_n is low, since all entries are invalid.
- match(i,j) = id_valid & id_src_used[i] & entry[j].valid & (id_src[i] == entry[j].dst).
- stall = ~flush & OR over i, j of match(i,j). Combinational from registered state and current inputs; zero-cycle latency.
- Per rising edge, with flush first:
  - If flush: all entries invalid. The decode instruction is not inserted.
  - Else: entry[k] <= entry[k-1] for k = 1..DEPTH-1.
  - entry[0] <= {id_valid & id_dst_write & ~stall, id_dst_addr, id_dst_is_load}. A stalled cycle therefore inserts a bubble (valid = 0).
  - The oldest entry drops off the end.
- Stall duration: a dependence on entry[j] stalls exactly DEPTH-j cycles, absent flush.
- Register 0 gets no special treatment; every specifier is a real register.
- stall_cycles:
  - +1 on every edge where stall = 1, saturating at all-ones.
  - cnt_clr has priority over the increment and clears to 0.
  - Independent of flush.
- Asynchronous reset mid-stall clears everything immediately. stall drops in the same cycle rst_n falls.
- Simultaneous matches on multiple sources or entries yield a single stall; no priority encoding is needed.

Optional Feature:
- Macro HAZARD_FWD_EN: forwarding-aware mode.
- Defined:
  - match(i,j) additionally requires j == 0 and entry[0].is_load.
  - Only load-use on the immediately preceding instruction stalls, for exactly 1 cycle.
  - ALU results are assumed forwarded by the EX/MEM bypass.
- Undefined:
  - is_load is ignored and need not be stored.
  - The full no-forwarding behaviour above applies.

Decomposition:
- Shared package hazard_pkg: REG_ADDR_W default, scoreboard-entry struct/typedef {valid, dst, is_load}, MAX_DEPTH = 4 constant.
- One natural sub-module: sat_counter (CNT_W, inc, clr), also reusable for other performance counters.
- Comparator array stays inline as a generate loop.

Test Plan:
- DEPTH=2, no FWD. Cycle 0: insert dst=R3 write. Cycle 1: decode src0=R3 used → stall=1 in cycles 1 and 2, 0 in cycle 3; stall_cycles=2.
- Decode src1=R5 but id_src_used=2'b01 while entry[0].dst=R5 valid → stall=0.
- Dependence pending (entry[0]=R2), flush=1 the same cycle → stall=0. Next cycle all entries invalid; a re-fetched R2 reader does not stall.
- With HAZARD_FWD_EN: load to R4 followed by a reader of R4 → stall for exactly 1 cycle. ALU write to R4 followed by a reader of R4 → no stall.
- Force stall continuously with CNT_W=4 → stall_cycles saturates at 15. cnt_clr=1 with stall=1 → 0 next edge.
- Assert rst_n low while stall=1 → stall=0 and stall_cycles=0 immediately; after release, the first decode never stalls.
